// File: rtl/spi_leader_if.sv
// Host-side and serial-side signals of the SPI leader, bundled for a single port.
// master is the leader itself; slave is whatever drives requests and MISO.
interface spi_leader_if #(
    parameter int DATA_LEN = 8
);
    logic                start;
    logic [DATA_LEN-1:0] tx_data;
    logic                miso;
    logic                sclk;
    logic                cs;
    logic                mosi;
    logic [DATA_LEN-1:0] rx_data;
    logic                busy;
    logic                done;

    modport master (
        input  start, tx_data, miso,
        output sclk, cs, mosi, rx_data, busy, done
    );

    modport slave (
        output start, tx_data, miso,
        input  sclk, cs, mosi, rx_data, busy, done
    );
endinterface

// File: rtl/spi_leader.sv
// SPI leader, mode 0 (CPOL=0), LSB first, chip select active low.
// Every output is a register loaded from the next-state logic, so nothing glitches.
module spi_leader #(
    parameter int DATA_LEN = 8,
    parameter int CLK_DIV  = 2
) (
    input  logic         clk,
    input  logic         rst,
    spi_leader_if.master bus
);
    localparam int BIT_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCLK_HI,
        SCLK_LO,
        HOLD,
        GAP
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_LEN-1:0] tx_q, tx_d;
    logic [DATA_LEN-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_LEN-1:0] rx_data_q, rx_data_d;
    logic                cs_q, cs_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                div_last;

    assign div_last = (div_q == DIV_LAST);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        // One shared half-period divider; it restarts at every phase change.
        if (state_q != IDLE) begin
            div_d = div_last ? 8'd0 : div_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tx_d    = bus.tx_data;
                    bit_d   = '0;
                    div_d   = 8'd0;
                    cs_d    = 1'b0;
                    mosi_d  = bus.tx_data[0];
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (div_last) begin
                    sclk_d  = 1'b1;
                    state_d = SCLK_HI;
                end
            end
            SCLK_HI: begin
                // Sampling late in the high phase tolerates a slow follower.
                if (div_last) begin
                    rx_shift_d = {bus.miso, rx_shift_q[DATA_LEN-1:1]};
                    tx_d       = tx_q >> 1;
                    mosi_d     = tx_q[1];
                    sclk_d     = 1'b0;
                    state_d    = SCLK_LO;
                end
            end
            SCLK_LO: begin
                if (div_last) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = HOLD;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        sclk_d  = 1'b1;
                        state_d = SCLK_HI;
                    end
                end
            end
            HOLD: begin
                if (div_last) begin
                    cs_d      = 1'b1;
                    mosi_d    = 1'b0;
                    rx_data_d = rx_shift_q;
                    done_d    = 1'b1;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (div_last) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= 8'd0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.sclk    = sclk_q;
    assign bus.cs      = cs_q;
    assign bus.mosi    = mosi_q;
    assign bus.rx_data = rx_data_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule
